alu_seq_ctrl: RTL and testbench
===============================

# alu_seq_ctrl

Sequencing controller for the 64-bit `alux64` ALU. It owns a 4-entry × 64-bit operand register file and a flag register {C,V,N,Z}. It accepts one command at a time over a valid/ready handshake, drives `alux64` from registered operands, writes results and flags back, and returns each result over a second valid/ready handshake. It sits between a command source (test sequencer or microcontroller FSM) and one combinational `alux64` instance, which it instantiates internally.

## Interface
- CNT_W, 16, width of the completed-ALU-operation counter

- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  command present
- in_ready  out  1  controller can accept a command
- in_op  in  2  0=ALU, 1=LOADI, 2=READ, 3=NOP
- in_sel  in  4  ALU select, driven to `alux64` S
- in_rd  in  2  destination register
- in_ra  in  2  operand A register (also READ source)
- in_rb  in  2  operand B register
- in_cin_mode  in  2  0: Cin=0; 1: Cin=1; 2: Cin=flag C; 3: Cin=0
- in_imm  in  64  LOADI data
- out_valid  out  1  response present
- out_ready  in  1  consumer takes response
- out_data  out  64  result / read data
- out_flags  out  4  {C,V,N,Z} after the command
- busy  out  1  state != IDLE
- ops_done  out  CNT_W  count of completed ALU commands, wraps

## Operation
- FSM states: IDLE, EXEC, RESP. Reset state is IDLE.
- IDLE: in_ready=1. A command is accepted on an edge with in_valid && in_ready.
  - ALU: latch reg[ra]→A_r, reg[rb]→B_r, in_sel→S_r, Cin per mode→Cin_r (mode 2 uses flag C as it stands at the accept edge), rd→rd_r. Next state is EXEC.
  - LOADI: reg[rd]←in_imm; out_data←in_imm; out_flags←current flags, unchanged. Next state is RESP.
  - READ: out_data←reg[ra]; out_flags←current flags. Next state is RESP.
  - NOP: out_data←0; out_flags←current flags. Next state is RESP.
- EXEC: `alux64` inputs come only from A_r/B_r/Cin_r/S_r.
  - At the end-of-EXEC edge: reg[rd_r]←O; flags←{Cout,Oflow,Ntive,Zero}; out_data←O; out_flags←the same flags; ops_done+1 (wraps at 2^CNT_W). Next state is RESP.
- RESP: out_valid=1, with out_data/out_flags held stable. On an edge with out_ready=1, move to IDLE. Otherwise hold indefinitely.
- rd equal to ra or rb is legal. Operands are latched before writeback.
- No command is accepted outside IDLE, and in_ready=0 there. Command inputs are ignored when in_ready=0.
- `alux64` is purely combinational. Its output is sampled only at the end of EXEC.

## Timing
- Reset values (next edge with rst=1): state IDLE, in_ready=1, out_valid=0, busy=0, out_data=0, out_flags=0, flags=0, all regs=0, A_r/B_r/S_r/Cin_r=0, ops_done=0.
- ALU latency: accept edge T → out_valid high in cycle T+2 (after the T+1 edge ends EXEC).
- LOADI/READ/NOP latency: out_valid high in the cycle after the accept edge.
- Response consumed at edge R. in_ready is high in cycle R+1. Next accept is at the earliest at edge R+1.
- Minimum period per command: 3 cycles for ALU, 2 cycles otherwise.
- rst mid-operation (EXEC or RESP): the pending command is dropped, no writeback occurs, and all state returns to reset values on that edge. rst has priority over every other event.
- in_valid deasserting after acceptance has no effect. out_ready asserted while out_valid=0 is ignored.

## Test plan
- Reset/idle: hold rst 2 cycles → in_ready=1, out_valid=0, busy=0, ops_done=0; READ r0..r3 each return 0 with flags 0.
- LOADI/READ: LOADI r1=F65927AB3081127E, then READ r1 → out_data=F65927AB3081127E one cycle after accept; flags unchanged (0).
- ALU path: LOADI r0=0FFFFFFFA0000000 and r1=00000001A1110000, then ALU sel=2, ra=0, rb=1, rd=2, cin_mode 0 → out_valid exactly 2 cycles after accept; out_data/out_flags equal a standalone `alux64`'s outputs for the same A/B/S/Cin=0; READ r2 matches; ops_done=1.
- Carry chain: ALU sel=3, cin_mode 2 after an op that set C=1 → reference Cin=1. Repeat after an op with C=0 → Cin=0.
- Backpressure: hold out_ready=0 for 5 cycles in RESP → out_valid and out_data stay stable, in_ready=0, a new in_valid is not accepted. Release → IDLE on the next cycle.
- Reset mid-op: assert rst in the EXEC cycle of an ALU op with rd=3 (reg3 preloaded with 1234) → reg3 reads 0 after reset, out_valid never asserts for that op, ops_done=0.

Source files
------------

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: one-command-at-a-time sequencer around alux64 (4x64 regfile, {C,V,N,Z} flags); cmd in via in_valid/in_ready, result out via out_valid/out_ready, busy, ops_done counter
module alux64 (
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic [3:0]  s,
  input  logic        cin,
  output logic [63:0] o,
  output logic        cout,
  output logic        oflow,
  output logic        ntive,
  output logic        zero
);
  logic [63:0] bx;
  logic [64:0] sum;
  logic        arith;
  always_comb begin
    bx    = s == 4'd3 ? ~b : s == 4'd14 ? 64'd0 : b;
    sum   = {1'b0, a} + {1'b0, bx} + {64'd0, cin};
    arith = s == 4'd2 || s == 4'd3 || s == 4'd14;
    o     = '0;
    cout  = 1'b0;
    case (s)
      4'd0:    o = a & b;
      4'd1:    o = a | b;
      4'd2, 4'd3, 4'd14: begin
        o    = sum[63:0];
        cout = sum[64];
      end
      4'd4:    o = a ^ b;
      4'd5:    o = ~a;
      4'd6:    o = a;
      4'd7:    o = b;
      4'd8: begin
        o    = {a[62:0], 1'b0};
        cout = a[63];
      end
      4'd9: begin
        o    = {1'b0, a[63:1]};
        cout = a[0];
      end
      4'd10: begin
        o    = {a[63], a[63:1]};
        cout = a[0];
      end
      4'd11:   o = ~(a & b);
      4'd12:   o = ~(a | b);
      4'd13:   o = ~(a ^ b);
      default: o = '0;
    endcase
    oflow = arith && a[63] == bx[63] && o[63] != a[63];
    ntive = o[63];
    zero  = o == '0;
  end
endmodule

module alu_seq_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [3:0]       in_sel,
  input  logic [1:0]       in_rd,
  input  logic [1:0]       in_ra,
  input  logic [1:0]       in_rb,
  input  logic [1:0]       in_cin_mode,
  input  logic [63:0]      in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_data,
  output logic [3:0]       out_flags,
  output logic             busy,
  output logic [CNT_W-1:0] ops_done
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t      state, state_nx;
  logic [63:0] regs [4];
  logic [3:0]  flags;
  logic [63:0] a_r, b_r;
  logic [3:0]  s_r;
  logic        cin_r;
  logic [1:0]  rd_r;
  logic [63:0] alu_o;
  logic        alu_c, alu_v, alu_n, alu_z;
  logic        accept;
  assign accept = in_valid && in_ready;
  alux64 u_alu (
    .a(a_r), .b(b_r), .s(s_r), .cin(cin_r),
    .o(alu_o), .cout(alu_c), .oflow(alu_v), .ntive(alu_n), .zero(alu_z)
  );
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_nx;
  always_comb begin
    state_nx = state == IDLE ? (accept ? (in_op == 2'd0 ? EXEC : RESP) : IDLE) :
               state == EXEC ? RESP : (out_ready ? IDLE : RESP);
  end
  always_comb begin
    in_ready  = state == IDLE;
    out_valid = state == RESP;
    busy      = state != IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) regs[i] <= '0;
      flags     <= '0;
      a_r       <= '0;
      b_r       <= '0;
      s_r       <= '0;
      cin_r     <= 1'b0;
      rd_r      <= '0;
      out_data  <= '0;
      out_flags <= '0;
      ops_done  <= '0;
    end else if (accept && in_op == 2'd0) begin
      a_r   <= regs[in_ra];
      b_r   <= regs[in_rb];
      s_r   <= in_sel;
      cin_r <= in_cin_mode == 2'd1 || (in_cin_mode == 2'd2 && flags[3]);
      rd_r  <= in_rd;
    end else if (accept) begin
      out_data  <= in_op == 2'd1 ? in_imm : in_op == 2'd2 ? regs[in_ra] : '0;
      out_flags <= flags;
      if (in_op == 2'd1) regs[in_rd] <= in_imm;
    end else if (state == EXEC) begin
      regs[rd_r] <= alu_o;
      flags      <= {alu_c, alu_v, alu_n, alu_z};
      out_data   <= alu_o;
      out_flags  <= {alu_c, alu_v, alu_n, alu_z};
      ops_done   <= ops_done + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb_alu_seq_ctrl: directed scoreboard bench for alu_seq_ctrl with an independent alux64 reference model
module tb_alu_seq_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  in_op = 2'd3;
  logic [3:0]  in_sel = '0;
  logic [1:0]  in_rd = '0, in_ra = '0, in_rb = '0, in_cin_mode = '0;
  logic [63:0] in_imm = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_data;
  logic [3:0]  out_flags;
  logic        busy;
  logic [15:0] ops_done;
  int total = 0;
  int bad = 0;
  logic [63:0] mreg [4];
  logic [3:0]  mflags;
  logic [15:0] mops;
  logic [67:0] sb [$];

  alu_seq_ctrl #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_sel(in_sel), .in_rd(in_rd), .in_ra(in_ra), .in_rb(in_rb),
    .in_cin_mode(in_cin_mode), .in_imm(in_imm), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_flags(out_flags),
    .busy(busy), .ops_done(ops_done)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout obs=running exp=finished");
    $fatal(1, "timeout");
  end

  function automatic logic [67:0] ref_alu(input logic [63:0] a, input logic [63:0] b,
                                          input logic [3:0] s, input logic c);
    logic [63:0] o, bb;
    logic [65:0] sx;
    logic [64:0] u;
    logic co, ov;
    co = 1'b0;
    ov = 1'b0;
    bb = (s == 4'd3) ? ~b : (s == 4'd14) ? 64'd0 : b;
    u  = {1'b0, a} + {1'b0, bb} + 65'(c);
    sx = {{2{a[63]}}, a} + {{2{bb[63]}}, bb} + 66'(c);
    case (s)
      4'd0:  o = a & b;
      4'd1:  o = a | b;
      4'd4:  o = a ^ b;
      4'd5:  o = ~a;
      4'd6:  o = a;
      4'd7:  o = b;
      4'd8:  begin o = a << 1; co = a[63]; end
      4'd9:  begin o = a >> 1; co = a[0]; end
      4'd10: begin o = 64'($signed(a) >>> 1); co = a[0]; end
      4'd11: o = ~(a & b);
      4'd12: o = ~(a | b);
      4'd13: o = ~(a ^ b);
      4'd15: o = 64'd0;
      default: begin o = u[63:0]; co = u[64]; ov = sx[64] != sx[63]; end
    endcase
    return {co, ov, o[63], o == 64'd0, o};
  endfunction

  task automatic chk(input string tag, input logic [67:0] obs, input logic [67:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) mreg[i] = '0;
    mflags = '0;
    mops = '0;
  endtask

  task automatic cmd(input logic [1:0] op, input logic [3:0] sel, input logic [1:0] rd,
                     input logic [1:0] ra, input logic [1:0] rb, input logic [1:0] cm,
                     input logic [63:0] imm, input int hold);
    logic [67:0] e;
    logic [63:0] d;
    logic c;
    int n;
    c = cm == 2'd1 || (cm == 2'd2 && mflags[3]);
    case (op)
      2'd0: begin
        e = ref_alu(mreg[ra], mreg[rb], sel, c);
        mreg[rd] = e[63:0];
        mflags = e[67:64];
        mops++;
      end
      2'd1: begin e = {mflags, imm}; mreg[rd] = imm; end
      2'd2: e = {mflags, mreg[ra]};
      default: e = {mflags, 64'd0};
    endcase
    sb.push_back(e);
    @(negedge clk);
    chk("in_ready_idle", 68'(in_ready), 68'd1);
    in_valid = 1'b1; in_op = op; in_sel = sel; in_rd = rd; in_ra = ra; in_rb = rb;
    in_cin_mode = cm; in_imm = imm;
    @(posedge clk);
    #1 in_valid = 1'b0; in_op = 2'd1; in_imm = {$urandom, $urandom}; in_rd = 2'($urandom);
    n = 0;
    do begin @(negedge clk); n++; end while (!out_valid && n < 8);
    chk("latency", 68'(n), (op == 2'd0) ? 68'd2 : 68'd1);
    e = sb.pop_front();
    chk("out_data", 68'(out_data), 68'(e[63:0]));
    chk("out_flags", 68'(out_flags), 68'(e[67:64]));
    if (op == 2'd0) chk("ops_done", 68'(ops_done), 68'(mops));
    if (hold > 0) begin
      d = out_data;
      in_valid = 1'b1;
      in_op = 2'd1;
      for (int k = 0; k < hold; k++) begin
        @(negedge clk);
        chk("bp_valid", 68'(out_valid), 68'd1);
        chk("bp_data", 68'(out_data), 68'(d));
        chk("bp_ready", 68'(in_ready), 68'd0);
      end
      in_valid = 1'b0;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    chk("post_in_ready", 68'(in_ready), 68'd1);
    chk("post_out_valid", 68'(out_valid), 68'd0);
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 68'(in_ready), 68'd1);
    chk("rst_out_valid", 68'(out_valid), 68'd0);
    chk("rst_busy", 68'(busy), 68'd0);
    chk("rst_ops_done", 68'(ops_done), 68'd0);
    chk("rst_out", {out_flags, out_data}, 68'd0);
    for (int i = 0; i < 4; i++) cmd(2'd2, 4'd0, 2'd0, 2'(i), 2'd0, 2'd0, 64'd0, 0);
    cmd(2'd1, 4'd0, 2'd1, 2'd0, 2'd0, 2'd0, 64'hF65927AB3081127E, 0);
    cmd(2'd2, 4'd0, 2'd0, 2'd1, 2'd0, 2'd0, 64'd0, 0);
    cmd(2'd3, 4'd0, 2'd0, 2'd0, 2'd0, 2'd0, 64'd0, 0);
    cmd(2'd1, 4'd0, 2'd0, 2'd0, 2'd0, 2'd0, 64'h0FFFFFFFA0000000, 0);
    cmd(2'd1, 4'd0, 2'd1, 2'd0, 2'd0, 2'd0, 64'h00000001A1110000, 0);
    cmd(2'd0, 4'd2, 2'd2, 2'd0, 2'd1, 2'd0, 64'd0, 0);
    chk("add_literal", 68'(mreg[2]), 68'h1000000141110000);
    cmd(2'd2, 4'd0, 2'd0, 2'd2, 2'd0, 2'd0, 64'd0, 0);
    cmd(2'd1, 4'd0, 2'd0, 2'd0, 2'd0, 2'd0, 64'hFFFFFFFFFFFFFFFF, 0);
    cmd(2'd1, 4'd0, 2'd1, 2'd0, 2'd0, 2'd0, 64'd1, 0);
    cmd(2'd0, 4'd2, 2'd2, 2'd0, 2'd1, 2'd0, 64'd0, 0);
    chk("carry_set", 68'(mflags), 68'h9);
    cmd(2'd0, 4'd3, 2'd3, 2'd1, 2'd1, 2'd2, 64'd0, 0);
    cmd(2'd0, 4'd2, 2'd2, 2'd1, 2'd1, 2'd0, 64'd0, 0);
    chk("carry_clear", 68'(mflags[3]), 68'd0);
    cmd(2'd0, 4'd3, 2'd3, 2'd1, 2'd1, 2'd2, 64'd0, 0);
    cmd(2'd0, 4'd2, 2'd0, 2'd0, 2'd0, 2'd0, 64'd0, 0);
    cmd(2'd0, 4'd3, 2'd3, 2'd1, 2'd1, 2'd3, 64'd0, 0);
    cmd(2'd0, 4'd3, 2'd3, 2'd1, 2'd1, 2'd1, 64'd0, 5);
    cmd(2'd2, 4'd0, 2'd0, 2'd3, 2'd0, 2'd0, 64'd0, 0);
    cmd(2'd1, 4'd0, 2'd0, 2'd0, 2'd0, 2'd0, {$urandom, $urandom}, 0);
    cmd(2'd1, 4'd0, 2'd1, 2'd0, 2'd0, 2'd0, {$urandom, $urandom}, 0);
    for (int s = 0; s < 16; s++) cmd(2'd0, 4'(s), 2'd2, 2'd0, 2'd1, 2'(s), 64'd0, 0);
    cmd(2'd1, 4'd0, 2'd0, 2'd0, 2'd0, 2'd0, 64'h7FFFFFFFFFFFFFFF, 0);
    cmd(2'd0, 4'd2, 2'd3, 2'd0, 2'd0, 2'd1, 64'd0, 0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    cmd(2'd1, 4'd0, 2'd3, 2'd0, 2'd0, 2'd0, 64'd1234, 0);
    @(negedge clk);
    in_valid = 1'b1; in_op = 2'd0; in_sel = 4'd2; in_rd = 2'd3; in_ra = 2'd3; in_rb = 2'd3;
    in_cin_mode = 2'd0;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("exec_busy", 68'(busy), 68'd1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("midrst_out_valid", 68'(out_valid), 68'd0);
    end
    chk("midrst_ops_done", 68'(ops_done), 68'd0);
    chk("midrst_in_ready", 68'(in_ready), 68'd1);
    cmd(2'd2, 4'd0, 2'd0, 2'd3, 2'd0, 2'd0, 64'd0, 0);
    chk("sb_empty", 68'(sb.size()), 68'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
